// File: rtl/if_id_queue.sv
// if_id_queue: decoupling FIFO between fetch and decode, replacing the IF/ID register.
// Holds {PC, instruction} pairs. Fetch stalls only when the queue is full.
// A branch or jump redirect (Q_Flush) discards every queued entry.
module if_id_queue #(
  parameter int DEPTH      = 2,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic [DATA_WIDTH-1:0] IF_PC,
  input  logic [DATA_WIDTH-1:0] IF_Instruction,
  input  logic                  IF_Valid,
  output logic                  IF_Ready,
  output logic [DATA_WIDTH-1:0] ID_PC,
  output logic [DATA_WIDTH-1:0] ID_Instruction,
  output logic                  ID_Valid,
  input  logic                  ID_Ready,
  input  logic                  Q_Flush,
  output logic [CNT_WIDTH-1:0]  Q_Count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } entry_t;

  entry_t               mem [DEPTH];
  logic [PTR_W-1:0]     rd_ptr, wr_ptr;
  logic [CNT_WIDTH-1:0] count;
  logic                 push, pop;

  // Ready and valid come only from the count register, so IF_Ready has no
  // combinational path from ID_Ready or Q_Flush.
  assign IF_Ready = (count != FULL);
  assign ID_Valid = (count != '0);
  assign push     = IF_Valid & IF_Ready;
  assign pop      = ID_Valid & ID_Ready;
  assign Q_Count  = count;

  // Head entry, masked to zero when empty: instruction 0 is the pipeline bubble.
  always_comb begin
    ID_PC          = '0;
    ID_Instruction = '0;
    if (ID_Valid) begin
      ID_PC          = mem[rd_ptr].pc;
      ID_Instruction = mem[rd_ptr].instr;
    end
  end

  // Storage write; contents are never cleared, the count masks stale data.
  always_ff @(posedge Clk) begin
    if (push && !Q_Flush) mem[wr_ptr] <= '{pc: IF_PC, instr: IF_Instruction};
  end

  // Pointer and occupancy update; flush beats any same-cycle push or pop.
  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (Q_Flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue (DEPTH = 2). Inputs change and outputs are
// sampled on the falling edge; state changes on the rising edge.
module tb_if_id_queue;

  localparam int DEPTH = 2;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic [DW-1:0] IF_PC, IF_Instruction;
  logic          IF_Valid, IF_Ready;
  logic [DW-1:0] ID_PC, ID_Instruction;
  logic          ID_Valid, ID_Ready, Q_Flush;
  logic [CW-1:0] Q_Count;

  int n_checks = 0;
  int n_fail   = 0;

  if_id_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .IF_PC(IF_PC), .IF_Instruction(IF_Instruction),
    .IF_Valid(IF_Valid), .IF_Ready(IF_Ready),
    .ID_PC(ID_PC), .ID_Instruction(ID_Instruction),
    .ID_Valid(ID_Valid), .ID_Ready(ID_Ready),
    .Q_Flush(Q_Flush), .Q_Count(Q_Count)
  );

  always #5 Clk = ~Clk;

  // Occupancy must stay within 0..DEPTH (underflow wraps to a large value).
  always @(negedge Clk) begin
    n_checks++;
    assert (Q_Count <= CW'(DEPTH)) else begin
      n_fail++;
      $display("FAIL count_bound: Q_Count=%0d exceeds %0d", Q_Count, DEPTH);
    end
  end

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic offer(input logic [DW-1:0] pc);
    IF_Valid       = 1'b1;
    IF_PC          = pc;
    IF_Instruction = pc + 32'h13;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; IF_Valid = 1'b0; ID_Ready = 1'b0; Q_Flush = 1'b0;
    IF_PC = '0; IF_Instruction = '0;
    #2;
    n_checks++;
    if (ID_Valid !== 1'b0 || Q_Count !== '0 || IF_Ready !== 1'b1 || ID_PC !== '0) begin
      n_fail++;
      $display("FAIL reset_state: ID_Valid=%b Q_Count=%0d IF_Ready=%b ID_PC=%h, want 0 0 1 0",
               ID_Valid, Q_Count, IF_Ready, ID_PC);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (ID_Valid !== 1'b0 || ID_Instruction !== '0 || IF_Ready !== 1'b1 || Q_Count !== '0) begin
        n_fail++;
        $display("FAIL idle_%0d: ID_Valid=%b instr=%h IF_Ready=%b Q_Count=%0d, want 0 0 1 0",
                 i, ID_Valid, ID_Instruction, IF_Ready, Q_Count);
      end
    end
  endtask

  task automatic test_pass_through();
    ID_Ready = 1'b1;
    IF_Valid = 1'b1; IF_PC = 32'h4; IF_Instruction = 32'h00500093;
    tick();
    IF_Valid = 1'b0;
    n_checks++;
    if (ID_Valid !== 1'b1 || ID_PC !== 32'h4 || ID_Instruction !== 32'h00500093 || Q_Count !== CW'(1)) begin
      n_fail++;
      $display("FAIL pass_head: valid=%b pc=%h instr=%h cnt=%0d, want 1 4 00500093 1",
               ID_Valid, ID_PC, ID_Instruction, Q_Count);
    end
    tick();
    n_checks++;
    if (Q_Count !== '0 || ID_Valid !== 1'b0 || ID_Instruction !== '0) begin
      n_fail++;
      $display("FAIL pass_drain: cnt=%0d valid=%b instr=%h, want 0 0 0", Q_Count, ID_Valid, ID_Instruction);
    end
  endtask

  task automatic test_fill_backpressure();
    ID_Ready = 1'b0;
    offer(32'h0);
    tick();
    offer(32'h4);
    n_checks++;
    if (IF_Ready !== 1'b1 || Q_Count !== CW'(1)) begin
      n_fail++;
      $display("FAIL fill_1: IF_Ready=%b cnt=%0d, want 1 1", IF_Ready, Q_Count);
    end
    tick();
    offer(32'h8);
    n_checks++;
    if (IF_Ready !== 1'b0 || Q_Count !== CW'(2) || ID_PC !== 32'h0 || ID_Instruction !== 32'h13) begin
      n_fail++;
      $display("FAIL fill_full: IF_Ready=%b cnt=%0d pc=%h instr=%h, want 0 2 0 13",
               IF_Ready, Q_Count, ID_PC, ID_Instruction);
    end
    tick();
    n_checks++;
    if (IF_Ready !== 1'b0 || Q_Count !== CW'(2) || ID_PC !== 32'h0) begin
      n_fail++;
      $display("FAIL fill_hold: IF_Ready=%b cnt=%0d pc=%h, want 0 2 0", IF_Ready, Q_Count, ID_PC);
    end
    ID_Ready = 1'b1;
    tick();
    n_checks++;
    if (ID_PC !== 32'h4 || Q_Count !== CW'(1) || IF_Ready !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_1: pc=%h cnt=%0d IF_Ready=%b, want 4 1 1", ID_PC, Q_Count, IF_Ready);
    end
    tick();
    IF_Valid = 1'b0;
    n_checks++;
    if (ID_PC !== 32'h8 || ID_Instruction !== 32'h1b || Q_Count !== CW'(1)) begin
      n_fail++;
      $display("FAIL drain_2: pc=%h instr=%h cnt=%0d, want 8 1b 1", ID_PC, ID_Instruction, Q_Count);
    end
    tick();
    n_checks++;
    if (Q_Count !== '0 || ID_Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_empty: cnt=%0d valid=%b, want 0 0", Q_Count, ID_Valid);
    end
  endtask

  task automatic test_back_to_back();
    ID_Ready = 1'b0;
    offer(32'h1000);
    tick();
    ID_Ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      offer(32'h1004 + 32'(4 * i));
      n_checks++;
      if (ID_PC !== 32'h1000 + 32'(4 * i) || Q_Count !== CW'(1)) begin
        n_fail++;
        $display("FAIL b2b_%0d: pc=%h cnt=%0d, want %h 1", i, ID_PC, Q_Count, 32'h1000 + 32'(4 * i));
      end
      tick();
    end
    IF_Valid = 1'b0;
    n_checks++;
    if (ID_PC !== 32'h1020 || Q_Count !== CW'(1)) begin
      n_fail++;
      $display("FAIL b2b_last: pc=%h cnt=%0d, want 1020 1", ID_PC, Q_Count);
    end
    tick();
    n_checks++;
    if (Q_Count !== '0) begin
      n_fail++;
      $display("FAIL b2b_drain: cnt=%0d, want 0", Q_Count);
    end
  endtask

  task automatic test_flush();
    ID_Ready = 1'b0;
    offer(32'h40); tick();
    offer(32'h44); tick();
    n_checks++;
    if (Q_Count !== CW'(2)) begin
      n_fail++;
      $display("FAIL flush_pre: cnt=%0d, want 2", Q_Count);
    end
    offer(32'h100); Q_Flush = 1'b1;
    tick();
    Q_Flush = 1'b0; IF_Valid = 1'b0;
    n_checks++;
    if (Q_Count !== '0 || ID_Valid !== 1'b0 || ID_Instruction !== '0 || ID_PC !== '0) begin
      n_fail++;
      $display("FAIL flush_full: cnt=%0d valid=%b pc=%h instr=%h, want 0 0 0 0",
               Q_Count, ID_Valid, ID_PC, ID_Instruction);
    end
    // Flush with one entry, a push accepted by the handshake and a pop.
    offer(32'h48); tick();
    offer(32'h104); ID_Ready = 1'b1; Q_Flush = 1'b1;
    n_checks++;
    if (IF_Ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_ready: IF_Ready=%b, want 1", IF_Ready);
    end
    tick();
    Q_Flush = 1'b0; IF_Valid = 1'b0;
    n_checks++;
    if (Q_Count !== '0 || ID_Valid !== 1'b0 || ID_PC !== '0) begin
      n_fail++;
      $display("FAIL flush_push: cnt=%0d valid=%b pc=%h, want 0 0 0", Q_Count, ID_Valid, ID_PC);
    end
    tick();
    n_checks++;
    if (ID_Valid !== 1'b0 || ID_PC === 32'h100 || ID_PC === 32'h104) begin
      n_fail++;
      $display("FAIL flush_dropped: valid=%b pc=%h, want 0 and no dropped PC", ID_Valid, ID_PC);
    end
  endtask

  task automatic test_async_reset();
    ID_Ready = 1'b0;
    offer(32'h60); tick();
    offer(32'h64); tick();
    IF_Valid = 1'b0;
    n_checks++;
    if (Q_Count !== CW'(2)) begin
      n_fail++;
      $display("FAIL arst_pre: cnt=%0d, want 2", Q_Count);
    end
    #2 Reset_n = 1'b0;
    #1;
    n_checks++;
    if (ID_Valid !== 1'b0 || Q_Count !== '0 || IF_Ready !== 1'b1 || ID_Instruction !== '0) begin
      n_fail++;
      $display("FAIL arst_async: valid=%b cnt=%0d IF_Ready=%b instr=%h, want 0 0 1 0",
               ID_Valid, Q_Count, IF_Ready, ID_Instruction);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    offer(32'h200);
    tick();
    IF_Valid = 1'b0;
    n_checks++;
    if (ID_Valid !== 1'b1 || ID_PC !== 32'h200 || Q_Count !== CW'(1)) begin
      n_fail++;
      $display("FAIL arst_head: valid=%b pc=%h cnt=%0d, want 1 200 1", ID_Valid, ID_PC, Q_Count);
    end
    ID_Ready = 1'b1;
    tick();
    n_checks++;
    if (ID_Valid !== 1'b0 || Q_Count !== '0) begin
      n_fail++;
      $display("FAIL arst_stale: valid=%b cnt=%0d pc=%h, want 0 0", ID_Valid, Q_Count, ID_PC);
    end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_fill_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
